// File: rtl/enc_bundle_scheduler.sv
// enc_bundle_scheduler: walks every HV dimension, fetches its bound-feature bits for the
// bundler, packs the thresholded bits into OUT_W-bit words and streams them out over valid/ready.
//   clk, rst_n             clock, asynchronous active-low reset
//   start_i / busy_o       begin one sample / encoding in progress
//   done_o                 one-cycle pulse after the last word handshake
//   rd_en_o, rd_addr_o     bound-vector read request, rd_data_i returns one cycle later
//   bundle_en_o            bits_to_bundle_o holds a live dimension
//   bits_to_bundle_o       registered feature bits, thresholded_bit_i is the bundler result
//   hv_word_o, hv_word_idx_o, hv_valid_o, hv_ready_i   packed word stream
module enc_bundle_scheduler #(
   parameter int FEATURE_COUNT = 617,
   parameter int HV_DIM        = 2048,
   parameter int OUT_W         = 32,
   parameter int DIM_W         = $clog2(HV_DIM),
   parameter int WIDX_W        = (HV_DIM / OUT_W > 1) ? $clog2(HV_DIM / OUT_W) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     rd_en_o,
   output logic [DIM_W-1:0]         rd_addr_o,
   input  logic [FEATURE_COUNT-1:0] rd_data_i,
   output logic                     bundle_en_o,
   output logic [FEATURE_COUNT-1:0] bits_to_bundle_o,
   input  logic                     thresholded_bit_i,
   output logic [OUT_W-1:0]         hv_word_o,
   output logic [WIDX_W-1:0]        hv_word_idx_o,
   output logic                     hv_valid_o,
   input  logic                     hv_ready_i
);
   localparam int BIT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] FLUSH = 2'd3;

   logic [1:0]               state_q, state_d;
   logic [DIM_W-1:0]         dim_q, dim_d;
   logic [BIT_W-1:0]         bit_q, bit_d, bit1_q, bit2_q;
   logic [WIDX_W-1:0]        word_q, word_d, idx_q, idx_d;
   logic [OUT_W-1:0]         pack_q, pack_d, hv_q, hv_d;
   logic [FEATURE_COUNT-1:0] bits_q;
   logic                     v1_q, be_q, valid_q, valid_d, done_q, done_d;
   logic                     start, issue, last_bit, last_word, hs, load;

   always_comb begin
      start     = state_q == IDLE && start_i;
      issue     = state_q == ISSUE;
      last_bit  = bit_q == BIT_W'(OUT_W - 1);
      last_word = word_q == WIDX_W'(HV_DIM / OUT_W - 1);
      hs        = valid_q && hv_ready_i;
      // the word is complete only once both pipeline stages have emptied
      load      = state_q == DRAIN && !v1_q && !be_q && (!valid_q || hv_ready_i);
      state_d   = start ? ISSUE :
                  (issue && last_bit) ? DRAIN :
                  load ? (last_word ? FLUSH : ISSUE) :
                  (state_q == FLUSH && done_q) ? IDLE : state_q;
      dim_d     = start ? '0 : issue ? dim_q + DIM_W'(1) : dim_q;
      bit_d     = start ? '0 : issue ? (last_bit ? '0 : bit_q + BIT_W'(1)) : bit_q;
      word_d    = start ? '0 : load ? word_q + WIDX_W'(1) : word_q;
      valid_d   = load ? 1'b1 : hs ? 1'b0 : valid_q;
      hv_d      = load ? pack_q : hv_q;
      idx_d     = load ? word_q : idx_q;
      done_d    = state_q == FLUSH && !done_q && hs;
      pack_d    = start ? '0 : pack_q;
      if (be_q) pack_d[bit2_q] = thresholded_bit_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dim_q   <= '0;
         bit_q   <= '0;
         bit1_q  <= '0;
         bit2_q  <= '0;
         word_q  <= '0;
         idx_q   <= '0;
         pack_q  <= '0;
         hv_q    <= '0;
         bits_q  <= '0;
         v1_q    <= 1'b0;
         be_q    <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dim_q   <= dim_d;
         bit_q   <= bit_d;
         bit1_q  <= bit_q;
         bit2_q  <= bit1_q;
         word_q  <= word_d;
         idx_q   <= idx_d;
         pack_q  <= pack_d;
         hv_q    <= hv_d;
         v1_q    <= issue;
         be_q    <= v1_q;
         valid_q <= valid_d;
         done_q  <= done_d;
         if (v1_q) bits_q <= rd_data_i;
      end
   end

   assign busy_o           = state_q != IDLE;
   assign done_o           = done_q;
   assign rd_en_o          = issue;
   assign rd_addr_o        = dim_q;
   assign bundle_en_o      = be_q;
   assign bits_to_bundle_o = bits_q;
   assign hv_word_o        = hv_q;
   assign hv_word_idx_o    = idx_q;
   assign hv_valid_o       = valid_q;
endmodule

// File: tb/tb_enc_bundle_scheduler.sv
// tb_enc_bundle_scheduler: table-driven and scoreboard bench for enc_bundle_scheduler at HV_DIM=64, OUT_W=32.
module tb_enc_bundle_scheduler;
   localparam int FC = 617;

   typedef struct {
      logic [63:0] pat;
      int          stall;
      bit          poke;
      logic [31:0] w0;
      logic [31:0] w1;
      int          hs0_at;
      int          done_at;
   } vec_t;

   typedef struct {
      logic [0:0]  idx;
      logic [31:0] word;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_i = 1'b0;
   logic          busy_o, done_o, rd_en_o, bundle_en_o, thresholded_bit_i, hv_valid_o;
   logic          hv_ready_i = 1'b0;
   logic [5:0]    rd_addr_o;
   logic [FC-1:0] rd_data_i;
   logic [FC-1:0] bits_to_bundle_o;
   logic [31:0]   hv_word_o;
   logic [0:0]    hv_word_idx_o;
   logic [63:0]   pat = '0;
   exp_t          sbq[$];
   vec_t          vt[5];
   int            n_cmp = 0;
   int            n_fail = 0;

   enc_bundle_scheduler #(.FEATURE_COUNT(FC), .HV_DIM(64), .OUT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
      .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
      .bundle_en_o(bundle_en_o), .bits_to_bundle_o(bits_to_bundle_o),
      .thresholded_bit_i(thresholded_bit_i), .hv_word_o(hv_word_o),
      .hv_word_idx_o(hv_word_idx_o), .hv_valid_o(hv_valid_o), .hv_ready_i(hv_ready_i)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) if (rd_en_o) rd_data_i <= {FC{pat[rd_addr_o]}};

   assign thresholded_bit_i = $countones(bits_to_bundle_o) > FC / 2;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_rd_en"}, rd_en_o, 0);
      chk({tag, "_rd_addr"}, rd_addr_o, 0);
      chk({tag, "_bundle_en"}, bundle_en_o, 0);
      chk({tag, "_bits"}, |bits_to_bundle_o, 0);
      chk({tag, "_word"}, hv_word_o, 0);
      chk({tag, "_idx"}, hv_word_idx_o, 0);
      chk({tag, "_valid"}, hv_valid_o, 0);
   endtask

   task automatic run(input vec_t v);
      int first_rd = -1, first_be = -1, first_v = -1, done_k = -1, hs0_k = -1, hs1_k = -1;
      int nrd = 0, nbe = 0;
      logic [1:0] rdh = '0;
      logic [31:0] pw = '0;
      logic [0:0] pi = '0;
      logic pstall = 1'b0;
      exp_t e;
      pat = v.pat;
      sbq.push_back('{1'b0, v.w0});
      sbq.push_back('{1'b1, v.w1});
      hv_ready_i = 1'b1;
      start_i = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         start_i = v.poke && (k == 5 || k == 71);
         if (k == 1) chk("busy_start", busy_o, 1);
         if (rd_en_o) begin
            if (first_rd < 0) first_rd = k;
            chk("rd_addr", rd_addr_o, nrd);
            nrd++;
         end
         chk("bundle_align", bundle_en_o, rdh[1]);
         rdh = {rdh[0], rd_en_o};
         if (bundle_en_o) begin
            if (first_be < 0) first_be = k;
            nbe++;
         end
         if (pstall) begin
            chk("hold_valid", hv_valid_o, 1);
            chk("hold_word", hv_word_o, pw);
            chk("hold_idx", hv_word_idx_o, pi);
         end
         if (hv_valid_o && first_v < 0) first_v = k;
         if (done_o) begin
            done_k = k;
            chk("busy_at_done", busy_o, 1);
         end
         if (done_k >= 0 && k == done_k + 1) begin
            chk("idle_after_done", busy_o, 0);
            break;
         end
         hv_ready_i = !(v.stall > 0 && first_v >= 0 && k < first_v + v.stall);
         if (hv_valid_o && hv_ready_i) begin
            if (hv_word_idx_o == 1'b0) hs0_k = k; else hs1_k = k;
            if (sbq.size() == 0) chk("unexpected_word", hv_word_o, 0);
            else begin
               e = sbq.pop_front();
               chk("word_idx", hv_word_idx_o, e.idx);
               chk("word_data", hv_word_o, e.word);
            end
         end
         pstall = hv_valid_o && !hv_ready_i;
         pw = hv_word_o;
         pi = hv_word_idx_o;
      end
      start_i = 1'b0;
      hv_ready_i = 1'b1;
      chk("first_rd_cycle", first_rd, 1);
      chk("first_be_cycle", first_be, 3);
      chk("first_valid_cycle", first_v, 36);
      chk("hs0_cycle", hs0_k, v.hs0_at);
      chk("hs1_cycle", hs1_k, v.done_at - 1);
      chk("done_cycle", done_k, v.done_at);
      chk("rd_count", nrd, 64);
      chk("bundle_count", nbe, 64);
      chk("sb_empty", sbq.size(), 0);
      sbq.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vt[0] = '{64'hFFFFFFFF_FFFFFFFF, 0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 36, 72};
      vt[1] = '{64'h55555555_55555555, 0, 1'b0, 32'h55555555, 32'h55555555, 36, 72};
      vt[2] = '{64'h01234567_89ABCDEF, 0, 1'b0, 32'h89ABCDEF, 32'h01234567, 36, 72};
      vt[3] = '{64'hDEADBEEF_CAFEF00D, 40, 1'b0, 32'hCAFEF00D, 32'hDEADBEEF, 76, 78};
      vt[4] = '{64'hA5A5A5A5_3C3C3C3C, 0, 1'b1, 32'h3C3C3C3C, 32'hA5A5A5A5, 36, 72};
      #3;
      check_zero("por");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         hv_ready_i = i[0];
         chk("idle_quiet", {busy_o, done_o, rd_en_o, bundle_en_o, hv_valid_o}, 0);
      end
      for (int i = 0; i < 5; i++) run(vt[i]);
      pat = '1;
      hv_ready_i = 1'b1;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int k = 0; k < 100 && !(rd_en_o && rd_addr_o == 6'd40); k++) @(negedge clk);
      chk("abort_reach", {rd_en_o, rd_addr_o}, {1'b1, 6'd40});
      rst_n = 1'b0;
      #1;
      check_zero("rst_async");
      @(negedge clk);
      check_zero("rst_held");
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_quiet", {busy_o, done_o, rd_en_o, bundle_en_o, hv_valid_o}, 0);
      end
      run('{64'h00FF00FF_F0F0F0F0, 0, 1'b0, 32'hF0F0F0F0, 32'h00FF00FF, 36, 72});
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
